// File: rtl/vector_sum_10_serial.sv
// rtl/vector_sum_10_serial.sv - serial ten-element signed vector reduction
module vector_sum_10_serial #(
    parameter int IN_WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       inReady,
    input  logic signed [IN_WIDTH-1:0] S0,
    input  logic signed [IN_WIDTH-1:0] S1,
    input  logic signed [IN_WIDTH-1:0] S2,
    input  logic signed [IN_WIDTH-1:0] S3,
    input  logic signed [IN_WIDTH-1:0] S4,
    input  logic signed [IN_WIDTH-1:0] S5,
    input  logic signed [IN_WIDTH-1:0] S6,
    input  logic signed [IN_WIDTH-1:0] S7,
    input  logic signed [IN_WIDTH-1:0] S8,
    input  logic signed [IN_WIDTH-1:0] S9,
    output logic                       outReady,
    output logic signed [IN_WIDTH+3:0] Sum,
    output logic                       earlyOutReady,
    output logic                       busy,
    output logic                       overrun
);

    localparam int SUM_W = IN_WIDTH + 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic signed [SUM_W-1:0]   acc_q, acc_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [IN_WIDTH-1:0]       buf_q [10];
    logic [IN_WIDTH-1:0]       buf_d [10];
    logic                      out_ready_q, out_ready_d;
    logic                      overrun_q, overrun_d;
    logic signed [SUM_W-1:0]   elem_ext;

    assign elem_ext = {{4{buf_q[idx_q][IN_WIDTH-1]}}, buf_q[idx_q]};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        buf_d       = buf_q;
        out_ready_d = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: begin
                if (inReady) begin
                    buf_d[0] = S0;
                    buf_d[1] = S1;
                    buf_d[2] = S2;
                    buf_d[3] = S3;
                    buf_d[4] = S4;
                    buf_d[5] = S5;
                    buf_d[6] = S6;
                    buf_d[7] = S7;
                    buf_d[8] = S8;
                    buf_d[9] = S9;
                    acc_d    = '0;
                    idx_d    = 4'd0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                // A new vector during a reduction is dropped, only flagged.
                if (inReady) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == 4'd9) begin
                    sum_d       = acc_q + elem_ext;
                    out_ready_d = 1'b1;
                    idx_d       = 4'd0;
                    state_d     = IDLE;
                end else begin
                    acc_d = acc_q + elem_ext;
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q       <= 4'd0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                buf_q[i] <= '0;
            end
        end else if (enable) begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_ready_q <= out_ready_d;
            overrun_q   <= overrun_d;
            buf_q       <= buf_d;
        end
    end

    assign outReady      = out_ready_q;
    assign Sum           = sum_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q == ACCUM);
    assign earlyOutReady = (state_q == ACCUM) && (idx_q == 4'd9);

endmodule

// File: doc/vector_sum_10_serial.md
VECTOR_SUM_10_SERIAL -- requirements
Module: vector_sum_10_serial

Interface
REQ-001 Parameter: IN_WIDTH, default 11, signed element width (matches VectorAdd_10 S outputs at adder IN_WIDTH=10).
REQ-002 Port: clk  input  1  single clock; all registers on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: enable  input  1  clock enable; 0 freezes every register.
REQ-005 Port: inReady  input  1  element vector valid, sampled on rising edge.
REQ-006 Port: S0..S9  input  IN_WIDTH each, signed  vector elements.
REQ-007 Port: outReady  output  1  registered pulse, Sum valid.
REQ-008 Port: Sum  output  IN_WIDTH+4, signed  reduction result S0+...+S9.
REQ-009 Port: earlyOutReady  output  1  high the cycle before outReady rises.
REQ-010 Port: busy  output  1  high while a reduction is in progress.
REQ-011 Port: overrun  output  1  sticky flag, inReady dropped while busy.

Function
REQ-012 FSM states SHALL be IDLE and ACCUM; element index idx SHALL be a 4-bit counter, 0..9.
REQ-013 All registers SHALL update only on edges with enable=1; reset overrides enable.
REQ-014 IDLE, inReady=1: SHALL latch S0..S9 into an internal element buffer, clear accumulator, set idx=0, go to ACCUM.
REQ-015 ACCUM, each enabled edge: accumulator += sign-extended buffer[idx]; idx += 1.
REQ-016 ACCUM with idx=9: SHALL load Sum with accumulator+buffer[9], set outReady=1, set idx=0, return to IDLE.
REQ-017 outReady SHALL clear on the next enabled edge; with enable=0 it holds its value.
REQ-018 Latency: capture at edge E0 -> outReady and new Sum visible after edge E10 (10 enabled edges).
REQ-019 earlyOutReady SHALL be combinational (state==ACCUM && idx==9), one enabled cycle before outReady.
REQ-020 busy SHALL equal (state==ACCUM).
REQ-021 Throughput: at most one vector per 11 enabled cycles; capture is allowed on the edge immediately after outReady rises.
REQ-022 inReady=1 on an enabled edge while in ACCUM: vector ignored, buffer/accumulator unchanged, overrun set to 1.
REQ-023 overrun SHALL clear only on reset.
REQ-024 Arithmetic: two's complement; IN_WIDTH+4 bits SHALL hold any 10-element sum without overflow.
REQ-025 Sum SHALL hold its value between completions; the buffer is not reloaded mid-reduction.
REQ-026 Input changes on S0..S9 after capture SHALL not affect the result.

Reset
REQ-027 reset=0 SHALL immediately, independent of clk: state=IDLE, idx=0, accumulator=0, buffer=0, Sum=0, outReady=0, overrun=0; thus busy=0, earlyOutReady=0.
REQ-028 Reset mid-ACCUM SHALL abort the reduction; no outReady pulse is produced for the aborted vector.
REQ-029 First capture SHALL be possible on the first enabled edge after reset deasserts.

Verification
REQ-030 All elements = 1, IN_WIDTH=11 -> earlyOutReady one cycle before outReady; outReady high after the 10th enabled edge following capture; Sum=10.
REQ-031 Elements 1023 each -> Sum=10230; elements -1024 each -> Sum=-10240; elements alternating 1023/-1024 -> Sum=-5.
REQ-032 enable=0 for 3 cycles at idx=4 -> idx, accumulator frozen; outReady arrives 3 cycles late; Sum unchanged (e.g. 10).
REQ-033 inReady pulse at idx=5 with a different vector -> overrun=1 and stays 1; Sum matches the first vector.
REQ-034 reset=0 asserted at idx=6 -> all outputs 0 asynchronously; no outReady; next vector of all 2 -> Sum=20.
REQ-035 Back-to-back: vectors of all 1 then all 3, second inReady on the edge after outReady -> Sum=10, then Sum=30; overrun=0.
